// File: rtl/pzvip_corebus_request_arbiter.sv
// Shares one corebus request port between N masters. Requests are registered with 1 cycle latency and arbitrated round-robin, with a lock held for multi-beat bursts.
// Backpressure: a port is ready only when it is granted and the output register is free. Responses are routed combinationally by the ID prefix.
module pzvip_corebus_request_arbiter #(
    parameter int N         = 2,
    parameter int ID_W      = 8,
    parameter int ADDR_W    = 64,
    parameter int LEN_W     = 10,
    parameter int DATA_W    = 128,
    parameter int MAX_OUTST = 4,
    localparam int PW       = (N == 1) ? 1 : $clog2(N),
    localparam int BE_W     = DATA_W / 8,
    localparam int OID_W    = ID_W + PW
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [N-1:0]          i_req_valid,
    output logic [N-1:0]          o_req_ready,
    input  logic [N*4-1:0]        i_req_command,
    input  logic [N*ID_W-1:0]     i_req_id,
    input  logic [N*ADDR_W-1:0]   i_req_address,
    input  logic [N*LEN_W-1:0]    i_req_length,
    input  logic [N*DATA_W-1:0]   i_req_data,
    input  logic [N*BE_W-1:0]     i_req_byte_enable,
    input  logic [N-1:0]          i_req_last,
    output logic                  o_req_valid,
    input  logic                  i_req_ready,
    output logic [3:0]            o_req_command,
    output logic [OID_W-1:0]      o_req_id,
    output logic [ADDR_W-1:0]     o_req_address,
    output logic [LEN_W-1:0]      o_req_length,
    output logic [DATA_W-1:0]     o_req_data,
    output logic [BE_W-1:0]       o_req_byte_enable,
    output logic                  o_req_last,
    input  logic                  i_res_valid,
    output logic                  o_res_ready,
    input  logic                  i_res_type,
    input  logic [OID_W-1:0]      i_res_id,
    input  logic                  i_res_error,
    input  logic [DATA_W-1:0]     i_res_data,
    input  logic [1:0]            i_res_last,
    output logic [N-1:0]          o_res_valid,
    input  logic [N-1:0]          i_res_ready,
    output logic                  o_res_type,
    output logic [ID_W-1:0]       o_res_id,
    output logic                  o_res_error,
    output logic [DATA_W-1:0]     o_res_data,
    output logic [1:0]            o_res_last,
    output logic                  o_res_drop
);

    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam logic [CW-1:0] OUTST_MAX = CW'(MAX_OUTST);

    typedef enum logic [0:0] {IDLE, LOCKED} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]     lock_port_q, lock_port_d;
    logic [CW-1:0]     outst_q [N];
    logic [CW-1:0]     outst_d [N];

    logic              req_vld_q, req_vld_d;
    logic [3:0]        req_cmd_q, req_cmd_d;
    logic [OID_W-1:0]  req_id_q, req_id_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [LEN_W-1:0]  req_len_q, req_len_d;
    logic [DATA_W-1:0] req_data_q, req_data_d;
    logic [BE_W-1:0]   req_be_q, req_be_d;
    logic              req_last_q, req_last_d;

    logic [N-1:0]      eligible;
    logic              gnt_vld;
    logic [PW-1:0]     gnt_idx;
    logic [3:0]        gnt_cmd;
    logic              gnt_last;
    logic              load_en;
    logic              accept;
    logic [PW-1:0]     res_idx;
    logic              res_mapped;
    logic              res_retire;
    logic [N-1:0]      cnt_inc, cnt_dec;

    // The outstanding mask only gates a request's first beat; a locked burst is never throttled.
    always_comb begin
        eligible = '0;
        for (int p = 0; p < N; p++) begin
            eligible[p] = i_req_valid[p] && !(i_req_command[p*4+3] && (outst_q[p] == OUTST_MAX));
        end
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        if (state_q == LOCKED) begin
            gnt_vld = i_req_valid[lock_port_q];
            gnt_idx = lock_port_q;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!gnt_vld && eligible[(int'(rr_ptr_q) + i) % N]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = PW'((int'(rr_ptr_q) + i) % N);
                end
            end
        end
    end

    assign gnt_cmd  = i_req_command[int'(gnt_idx)*4 +: 4];
    assign gnt_last = i_req_last[gnt_idx];
    assign load_en  = !req_vld_q || i_req_ready;
    assign accept   = gnt_vld && load_en;

    always_comb begin
        o_req_ready = '0;
        if (i_rst_n && accept) begin
            o_req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        lock_port_d = lock_port_q;
        if (accept) begin
            rr_ptr_d = PW'((int'(gnt_idx) + 1) % N);
            if (state_q == IDLE) begin
                if (!gnt_last) begin
                    state_d     = LOCKED;
                    lock_port_d = gnt_idx;
                end
            end else if (gnt_last) begin
                state_d = IDLE;
            end
        end
    end

    always_comb begin
        req_vld_d  = req_vld_q;
        req_cmd_d  = req_cmd_q;
        req_id_d   = req_id_q;
        req_addr_d = req_addr_q;
        req_len_d  = req_len_q;
        req_data_d = req_data_q;
        req_be_d   = req_be_q;
        req_last_d = req_last_q;
        if (load_en) begin
            req_vld_d = gnt_vld;
            if (gnt_vld) begin
                req_cmd_d  = gnt_cmd;
                req_id_d   = {gnt_idx, i_req_id[int'(gnt_idx)*ID_W +: ID_W]};
                req_addr_d = i_req_address[int'(gnt_idx)*ADDR_W +: ADDR_W];
                req_len_d  = i_req_length[int'(gnt_idx)*LEN_W +: LEN_W];
                req_data_d = i_req_data[int'(gnt_idx)*DATA_W +: DATA_W];
                req_be_d   = i_req_byte_enable[int'(gnt_idx)*BE_W +: BE_W];
                req_last_d = gnt_last;
            end
        end
    end

    // Unmapped prefixes are sunk so a stray response can never stall the downstream port.
    assign res_idx    = i_res_id[ID_W +: PW];
    assign res_mapped = (int'(res_idx) < N);
    assign res_retire = i_res_valid && res_mapped && i_res_ready[res_idx] && i_res_last[0];

    always_comb begin
        o_res_valid = '0;
        o_res_ready = 1'b1;
        if (res_mapped) begin
            o_res_ready          = i_res_ready[res_idx];
            o_res_valid[res_idx] = i_res_valid && i_rst_n;
        end
    end

    assign o_res_drop  = i_rst_n && i_res_valid && !res_mapped;
    assign o_res_type  = i_res_type;
    assign o_res_id    = i_res_id[ID_W-1:0];
    assign o_res_error = i_res_error;
    assign o_res_data  = i_res_data;
    assign o_res_last  = i_res_last;

    always_comb begin
        cnt_inc = '0;
        cnt_dec = '0;
        for (int p = 0; p < N; p++) begin
            cnt_inc[p] = accept && (state_q == IDLE) && gnt_cmd[3] && (gnt_idx == PW'(p));
            cnt_dec[p] = res_retire && (res_idx == PW'(p));
            outst_d[p] = outst_q[p];
            if (cnt_inc[p] && !cnt_dec[p] && (outst_q[p] != OUTST_MAX)) begin
                outst_d[p] = outst_q[p] + 1'b1;
            end else if (cnt_dec[p] && !cnt_inc[p] && (outst_q[p] != '0)) begin
                outst_d[p] = outst_q[p] - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            lock_port_q <= '0;
            for (int p = 0; p < N; p++) begin
                outst_q[p] <= '0;
            end
            req_vld_q   <= 1'b0;
            req_cmd_q   <= '0;
            req_id_q    <= '0;
            req_addr_q  <= '0;
            req_len_q   <= '0;
            req_data_q  <= '0;
            req_be_q    <= '0;
            req_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_port_q <= lock_port_d;
            for (int p = 0; p < N; p++) begin
                outst_q[p] <= outst_d[p];
            end
            req_vld_q   <= req_vld_d;
            req_cmd_q   <= req_cmd_d;
            req_id_q    <= req_id_d;
            req_addr_q  <= req_addr_d;
            req_len_q   <= req_len_d;
            req_data_q  <= req_data_d;
            req_be_q    <= req_be_d;
            req_last_q  <= req_last_d;
        end
    end

    assign o_req_valid       = req_vld_q;
    assign o_req_command     = req_cmd_q;
    assign o_req_id          = req_id_q;
    assign o_req_address     = req_addr_q;
    assign o_req_length      = req_len_q;
    assign o_req_data        = req_data_q;
    assign o_req_byte_enable = req_be_q;
    assign o_req_last        = req_last_q;

endmodule

// File: tb/tb_pzvip_corebus_request_arbiter.sv
// Directed bench for the corebus request arbiter: N=3 ports, MAX_OUTST=2.
// Inputs change on the falling edge; outputs are compared 1ns later.
module tb_pzvip_corebus_request_arbiter;

    localparam logic [3:0] RD = 4'h8;
    localparam logic [3:0] WR = 4'h1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req_valid, req_rdy_o, req_last;
    logic [11:0] req_cmd, req_be;
    logic [23:0] req_id;
    logic [47:0] req_addr;
    logic [29:0] req_len;
    logic [95:0] req_data;
    logic        o_valid, ds_ready, o_last;
    logic [3:0]  o_cmd, o_be;
    logic [9:0]  o_id, o_len;
    logic [15:0] o_addr;
    logic [31:0] o_data;
    logic        res_valid_i, res_ready_o, res_type_i, res_err_i, res_type_o, res_err_o, res_drop;
    logic [9:0]  res_id_i;
    logic [7:0]  res_id_o;
    logic [31:0] res_data_i, res_data_o;
    logic [1:0]  res_last_i, res_last_o;
    logic [2:0]  res_valid_o, res_ready_i;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pzvip_corebus_request_arbiter #(
        .N(3), .ID_W(8), .ADDR_W(16), .LEN_W(10), .DATA_W(32), .MAX_OUTST(2)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_rdy_o), .i_req_command(req_cmd),
        .i_req_id(req_id), .i_req_address(req_addr), .i_req_length(req_len),
        .i_req_data(req_data), .i_req_byte_enable(req_be), .i_req_last(req_last),
        .o_req_valid(o_valid), .i_req_ready(ds_ready), .o_req_command(o_cmd),
        .o_req_id(o_id), .o_req_address(o_addr), .o_req_length(o_len),
        .o_req_data(o_data), .o_req_byte_enable(o_be), .o_req_last(o_last),
        .i_res_valid(res_valid_i), .o_res_ready(res_ready_o), .i_res_type(res_type_i),
        .i_res_id(res_id_i), .i_res_error(res_err_i), .i_res_data(res_data_i),
        .i_res_last(res_last_i), .o_res_valid(res_valid_o), .i_res_ready(res_ready_i),
        .o_res_type(res_type_o), .o_res_id(res_id_o), .o_res_error(res_err_o),
        .o_res_data(res_data_o), .o_res_last(res_last_o), .o_res_drop(res_drop)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input int p, input logic v, input logic [3:0] c, input logic [7:0] id,
                         input logic [31:0] d, input logic l);
        req_valid[p]           = v;
        req_cmd[p*4 +: 4]      = c;
        req_id[p*8 +: 8]       = id;
        req_addr[p*16 +: 16]   = {8'hA0, id};
        req_len[p*10 +: 10]    = 10'd4;
        req_data[p*32 +: 32]   = d;
        req_be[p*4 +: 4]       = 4'hF;
        req_last[p]            = l;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0; req_cmd = '0; req_be = '0; req_id = '0; req_addr = '0;
        req_len = '0; req_data = '0; req_last = '0; ds_ready = 1'b1;
        res_valid_i = 1'b0; res_type_i = 1'b0; res_err_i = 1'b0; res_id_i = '0;
        res_data_i = '0; res_last_i = '0; res_ready_i = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        drive(0, 1, RD, 8'h11, 0, 1);
        drive(1, 1, RD, 8'h22, 0, 1);
        res_valid_i = 1'b1; res_id_i = {2'd0, 8'h10}; res_ready_i = 3'b111;
        #1;
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL rst_o_valid got %b want 0", o_valid); end
        n_cmp++; if (req_rdy_o !== 3'b000) begin n_bad++; $display("FAIL rst_req_ready got %b want 000", req_rdy_o); end
        n_cmp++; if (res_valid_o !== 3'b000) begin n_bad++; $display("FAIL rst_res_valid got %b want 000", res_valid_o); end
        res_id_i = {2'd3, 8'h10};
        #1;
        n_cmp++; if (res_drop !== 1'b0) begin n_bad++; $display("FAIL rst_res_drop got %b want 0", res_drop); end
        tick();
        #1;
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL rst_hold_o_valid got %b want 0", o_valid); end
    endtask

    task automatic test_round_robin();
        do_reset();
        drive(0, 1, RD, 8'h11, 0, 1);
        drive(1, 1, RD, 8'h22, 0, 1);
        #1;
        n_cmp++; if (req_rdy_o !== 3'b001) begin n_bad++; $display("FAIL rr_first_ready got %b want 001", req_rdy_o); end
        tick();
        drive(0, 0, RD, 8'h11, 0, 1);
        #1;
        n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL rr_valid0 got %b want 1", o_valid); end
        n_cmp++; if (o_id !== 10'h011) begin n_bad++; $display("FAIL rr_id0 got %h want 011", o_id); end
        n_cmp++; if (req_rdy_o !== 3'b010) begin n_bad++; $display("FAIL rr_second_ready got %b want 010", req_rdy_o); end
        tick();
        drive(1, 0, RD, 8'h22, 0, 1);
        #1;
        n_cmp++; if (o_id !== 10'h122) begin n_bad++; $display("FAIL rr_id1 got %h want 122", o_id); end
        n_cmp++; if (o_cmd !== RD) begin n_bad++; $display("FAIL rr_cmd1 got %h want %h", o_cmd, RD); end
        tick();
        #1;
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL rr_idle got %b want 0", o_valid); end
    endtask

    task automatic test_burst_lock();
        do_reset();
        drive(1, 1, RD, 8'h22, 0, 1);
        for (int b = 0; b < 4; b++) begin
            drive(0, 1, WR, 8'h33, 32'hD0 + b, (b == 3));
            #1;
            n_cmp++; if (req_rdy_o !== 3'b001) begin n_bad++; $display("FAIL lock_ready beat%0d got %b want 001", b, req_rdy_o); end
            tick();
            #1;
            n_cmp++; if (o_data !== 32'hD0 + b) begin n_bad++; $display("FAIL lock_data beat%0d got %h want %h", b, o_data, 32'hD0 + b); end
            n_cmp++; if (o_last !== (b == 3)) begin n_bad++; $display("FAIL lock_last beat%0d got %b want %b", b, o_last, (b == 3)); end
        end
        drive(0, 0, WR, 8'h33, 0, 0);
        #1;
        n_cmp++; if (req_rdy_o !== 3'b010) begin n_bad++; $display("FAIL lock_release_ready got %b want 010", req_rdy_o); end
        tick();
        drive(1, 0, RD, 8'h22, 0, 1);
        #1;
        n_cmp++; if (o_id !== 10'h122) begin n_bad++; $display("FAIL lock_port1_id got %h want 122", o_id); end
        tick();
    endtask

    task automatic test_throttle();
        do_reset();
        drive(0, 1, RD, 8'h01, 0, 1);
        #1;
        n_cmp++; if (req_rdy_o !== 3'b001) begin n_bad++; $display("FAIL thr_rd1 got %b want 001", req_rdy_o); end
        tick();
        drive(0, 1, RD, 8'h02, 0, 1);
        #1;
        n_cmp++; if (req_rdy_o !== 3'b001) begin n_bad++; $display("FAIL thr_rd2 got %b want 001", req_rdy_o); end
        tick();
        drive(0, 1, RD, 8'h03, 0, 1);
        #1;
        n_cmp++; if (req_rdy_o !== 3'b000) begin n_bad++; $display("FAIL thr_rd3_stall got %b want 000", req_rdy_o); end
        tick();
        #1;
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL thr_no_out got %b want 0", o_valid); end
        res_valid_i = 1'b1; res_id_i = {2'd0, 8'h01}; res_last_i = 2'b01; res_ready_i = 3'b001;
        res_data_i = 32'hCAFE_0001; res_type_i = 1'b1;
        #1;
        n_cmp++; if (res_valid_o !== 3'b001) begin n_bad++; $display("FAIL thr_res_valid got %b want 001", res_valid_o); end
        n_cmp++; if (res_ready_o !== 1'b1) begin n_bad++; $display("FAIL thr_res_ready got %b want 1", res_ready_o); end
        n_cmp++; if (res_id_o !== 8'h01) begin n_bad++; $display("FAIL thr_res_id got %h want 01", res_id_o); end
        n_cmp++; if (res_data_o !== 32'hCAFE_0001) begin n_bad++; $display("FAIL thr_res_data got %h want cafe0001", res_data_o); end
        n_cmp++; if (req_rdy_o !== 3'b000) begin n_bad++; $display("FAIL thr_still_stall got %b want 000", req_rdy_o); end
        tick();
        res_valid_i = 1'b0;
        #1;
        n_cmp++; if (req_rdy_o !== 3'b001) begin n_bad++; $display("FAIL thr_rd3_go got %b want 001", req_rdy_o); end
        tick();
        drive(0, 0, RD, 8'h03, 0, 1);
        #1;
        n_cmp++; if (o_id !== 10'h003) begin n_bad++; $display("FAIL thr_rd3_id got %h want 003", o_id); end
        tick();
    endtask

    task automatic test_back_to_back_stall();
        do_reset();
        drive(0, 1, WR, 8'h44, 32'hA1, 1);
        tick();
        drive(0, 1, WR, 8'h45, 32'hB2, 1);
        drive(1, 1, WR, 8'h55, 32'hC3, 1);
        ds_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid cyc%0d got %b want 1", c, o_valid); end
            n_cmp++; if (o_data !== 32'hA1) begin n_bad++; $display("FAIL stall_data cyc%0d got %h want a1", c, o_data); end
            n_cmp++; if (req_rdy_o !== 3'b000) begin n_bad++; $display("FAIL stall_ready cyc%0d got %b want 000", c, req_rdy_o); end
            tick();
        end
        ds_ready = 1'b1;
        #1;
        n_cmp++; if (req_rdy_o !== 3'b010) begin n_bad++; $display("FAIL stall_release_ready got %b want 010", req_rdy_o); end
        tick();
        drive(1, 0, WR, 8'h55, 0, 1);
        #1;
        n_cmp++; if (o_data !== 32'hC3) begin n_bad++; $display("FAIL stall_next_data got %h want c3", o_data); end
        n_cmp++; if (req_rdy_o !== 3'b001) begin n_bad++; $display("FAIL stall_p0_ready got %b want 001", req_rdy_o); end
        tick();
        drive(0, 0, WR, 8'h45, 0, 1);
        #1;
        n_cmp++; if (o_data !== 32'hB2) begin n_bad++; $display("FAIL stall_last_data got %h want b2", o_data); end
        tick();
        #1;
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL stall_drained got %b want 0", o_valid); end
    endtask

    task automatic test_res_routing();
        do_reset();
        res_valid_i = 1'b1; res_id_i = {2'd3, 8'h55}; res_ready_i = 3'b000; res_last_i = 2'b01;
        #1;
        n_cmp++; if (res_ready_o !== 1'b1) begin n_bad++; $display("FAIL drop_ready got %b want 1", res_ready_o); end
        n_cmp++; if (res_valid_o !== 3'b000) begin n_bad++; $display("FAIL drop_valid got %b want 000", res_valid_o); end
        n_cmp++; if (res_drop !== 1'b1) begin n_bad++; $display("FAIL drop_pulse got %b want 1", res_drop); end
        tick();
        res_valid_i = 1'b0;
        #1;
        n_cmp++; if (res_drop !== 1'b0) begin n_bad++; $display("FAIL drop_end got %b want 0", res_drop); end
        res_valid_i = 1'b1; res_id_i = {2'd2, 8'h66};
        #1;
        n_cmp++; if (res_valid_o !== 3'b100) begin n_bad++; $display("FAIL route2_valid got %b want 100", res_valid_o); end
        n_cmp++; if (res_ready_o !== 1'b0) begin n_bad++; $display("FAIL route2_ready got %b want 0", res_ready_o); end
        n_cmp++; if (res_id_o !== 8'h66) begin n_bad++; $display("FAIL route2_id got %h want 66", res_id_o); end
        res_valid_i = 1'b0;
    endtask

    task automatic test_counter_floor();
        do_reset();
        res_valid_i = 1'b1; res_id_i = {2'd1, 8'h77}; res_last_i = 2'b01; res_ready_i = 3'b010;
        tick();
        res_valid_i = 1'b0;
        drive(1, 1, RD, 8'h21, 0, 1);
        #1;
        n_cmp++; if (req_rdy_o !== 3'b010) begin n_bad++; $display("FAIL floor_rd1 got %b want 010", req_rdy_o); end
        tick();
        drive(1, 1, RD, 8'h22, 0, 1);
        #1;
        n_cmp++; if (req_rdy_o !== 3'b010) begin n_bad++; $display("FAIL floor_rd2 got %b want 010", req_rdy_o); end
        tick();
        drive(1, 1, RD, 8'h23, 0, 1);
        #1;
        n_cmp++; if (req_rdy_o !== 3'b000) begin n_bad++; $display("FAIL floor_rd3 got %b want 000", req_rdy_o); end
        tick();
        drive(1, 0, RD, 8'h23, 0, 1);
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        drive(1, 1, RD, 8'h22, 0, 1);
        for (int b = 0; b < 2; b++) begin
            drive(0, 1, WR, 8'h33, 32'hE0 + b, 0);
            tick();
        end
        drive(0, 1, WR, 8'h33, 32'hE2, 0);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid got %b want 0", o_valid); end
        n_cmp++; if (req_rdy_o !== 3'b000) begin n_bad++; $display("FAIL midrst_ready got %b want 000", req_rdy_o); end
        tick();
        drive(0, 0, WR, 8'h33, 0, 0);
        rst_n = 1'b1;
        #1;
        n_cmp++; if (req_rdy_o !== 3'b010) begin n_bad++; $display("FAIL midrst_p1_ready got %b want 010", req_rdy_o); end
        tick();
        drive(1, 0, RD, 8'h22, 0, 1);
        #1;
        n_cmp++; if (o_id !== 10'h122) begin n_bad++; $display("FAIL midrst_p1_id got %h want 122", o_id); end
        tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_burst_lock();
        test_throttle();
        test_back_to_back_stall();
        test_res_routing();
        test_counter_floor();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
